median_frame_sched: RTL

//  Frame-level scheduler for the 3x3 median-filter datapath. Walks the image in raster order,

---
 rtl/median_frame_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/median_frame_sched.sv
//------------------------------------------------------------------------------
// Module  : median_frame_sched
// Brief   : Raster-order frame scheduler for the 3x3 median filter datapath.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module median_frame_sched #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int ADDR_W    = 19,
    parameter int WD_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              win_done,
    input  logic              stall,
    output logic              win_start,
    output logic [9:0]        win_x,
    output logic [8:0]        win_y,
    output logic [ADDR_W-1:0] center_addr,
    output logic              border,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout
);

    localparam int               c_WD_W    = $clog2(WD_CYCLES);
    localparam logic [9:0]       c_X_LAST  = 10'(IMG_W - 1);
    localparam logic [8:0]       c_Y_LAST  = 9'(IMG_H - 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(WD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [9:0]          r_x;
    logic [8:0]          r_y;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_WD_W-1:0]   r_wd;
    logic                w_edge;
    logic                w_last;
    logic                w_win_start;
    logic                w_wr_en;
    logic                w_frame_done;

    assign w_edge = (r_x == 10'd0) || (r_x == c_X_LAST) ||
                    (r_y == 9'd0)  || (r_y == c_Y_LAST);
    assign w_last = (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Abort overrides everything, including this cycle's strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_win_start  = 1'b0;
        w_wr_en      = 1'b0;
        w_frame_done = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) w_state_nxt = S_ISSUE;
                end
                S_ISSUE: begin
                    if (w_edge) begin
                        w_state_nxt = S_WRITE;
                    end else begin
                        w_win_start = 1'b1;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (win_done)               w_state_nxt = S_WRITE;
                    else if (r_wd == c_WD_LAST) w_state_nxt = S_ERR;
                end
                S_WRITE: begin
                    if (!stall) begin
                        w_wr_en     = 1'b1;
                        w_state_nxt = S_NEXT;
                    end
                end
                S_NEXT: begin
                    w_state_nxt = w_last ? S_DONE : S_ISSUE;
                end
                S_DONE: begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
                S_ERR: begin
                    if (start) w_state_nxt = S_ISSUE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Address advances by one per pixel so no y*IMG_W multiply is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
            r_wd   <= '0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        r_x    <= '0;
                        r_y    <= '0;
                        r_addr <= '0;
                    end
                end
                S_ISSUE: r_wd <= '0;
                S_WAIT: begin
                    if (!win_done && (r_wd != c_WD_LAST)) r_wd <= r_wd + 1'b1;
                end
                S_NEXT: begin
                    if (!w_last) begin
                        if (r_x == c_X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign win_start   = w_win_start;
    assign wr_en       = w_wr_en;
    assign frame_done  = w_frame_done;
    assign win_x       = r_x;
    assign win_y       = r_y;
    assign center_addr = r_addr;
    assign wr_addr     = r_addr;
    assign border      = w_edge && ((r_state == S_ISSUE) || (r_state == S_WAIT) ||
                                    (r_state == S_WRITE));
    assign busy        = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                         (r_state == S_WRITE) || (r_state == S_NEXT) ||
                         (r_state == S_DONE);
    assign err_timeout = (r_state == S_ERR);

endmodule

`default_nettype wire
